// File: rtl/mips_pkg.sv
// Shared MIPS definitions: datapath widths, register-file geometry and
// named architectural register indices.
package mips_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 2 ** ADDR_W;

   localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
   localparam logic [ADDR_W-1:0] REG_AT   = 5'd1;
   localparam logic [ADDR_W-1:0] REG_V0   = 5'd2;
   localparam logic [ADDR_W-1:0] REG_A0   = 5'd4;
   localparam logic [ADDR_W-1:0] REG_T0   = 5'd8;
   localparam logic [ADDR_W-1:0] REG_T1   = 5'd9;
   localparam logic [ADDR_W-1:0] REG_T2   = 5'd10;
   localparam logic [ADDR_W-1:0] REG_GP   = 5'd28;
   localparam logic [ADDR_W-1:0] REG_SP   = 5'd29;
   localparam logic [ADDR_W-1:0] REG_FP   = 5'd30;
   localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

endpackage

// File: rtl/wb_regfile_writeback_if.sv
// Bus between the MEM/WB buffer, the ID stage and the write-back/register
// bank block. The pipeline side is the master, the register bank the slave.
interface wb_regfile_writeback_if
   import mips_pkg::*;
#(
   parameter int DATA_W = mips_pkg::DATA_W,
   parameter int ADDR_W = mips_pkg::ADDR_W
);

   logic [DATA_W-1:0] in_MemDatos_WB;
   logic [DATA_W-1:0] in_ALU_WB;
   logic [ADDR_W-1:0] in_WriteReg;
   logic              in_RegWrite;
   logic              in_MemToReg;
   logic [ADDR_W-1:0] in_ReadReg1;
   logic [ADDR_W-1:0] in_ReadReg2;
   logic [DATA_W-1:0] out_ReadData1;
   logic [DATA_W-1:0] out_ReadData2;
   logic [DATA_W-1:0] out_WB_Data;
   logic [ADDR_W-1:0] out_WB_Addr;
   logic              out_WB_En;
   logic [31:0]       out_WriteCount;

   modport master (
      output in_MemDatos_WB, in_ALU_WB, in_WriteReg, in_RegWrite, in_MemToReg,
             in_ReadReg1, in_ReadReg2,
      input  out_ReadData1, out_ReadData2, out_WB_Data, out_WB_Addr, out_WB_En,
             out_WriteCount
   );

   modport slave (
      input  in_MemDatos_WB, in_ALU_WB, in_WriteReg, in_RegWrite, in_MemToReg,
             in_ReadReg1, in_ReadReg2,
      output out_ReadData1, out_ReadData2, out_WB_Data, out_WB_Addr, out_WB_En,
             out_WriteCount
   );

endinterface

// File: rtl/wb_regfile_writeback_reg_bank.sv
// Register bank: NUM_REGS x DATA_W array, one synchronous write port, two
// combinational read ports. Entry 0 is hardwired to zero.
module wb_regfile_writeback_reg_bank
   import mips_pkg::*;
#(
   parameter int DATA_W = mips_pkg::DATA_W,
   parameter int ADDR_W = mips_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wrEn,
   input  logic [ADDR_W-1:0] wrAddr,
   input  logic [DATA_W-1:0] wrData,
   input  logic [ADDR_W-1:0] rdAddr1,
   input  logic [ADDR_W-1:0] rdAddr2,
   output logic [DATA_W-1:0] rdData1,
   output logic [DATA_W-1:0] rdData2
);

   localparam int NUM_ENTRIES = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs [NUM_ENTRIES];

   // Array update: clear everything on reset, otherwise commit one write per cycle.
   // NOTE: every entry is reset so reads of never-written registers return 0, not X;
   // this costs a reset net per flop, which a RAM macro could not provide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            // NOTE: non-blocking assignment keeps all flops sampling pre-edge values.
            regs[i] <= '0;
         end
      end else if (wrEn && (wrAddr != '0)) begin
         regs[wrAddr] <= wrData;
      end
   end

   assign rdData1 = (rdAddr1 == '0) ? '0 : regs[rdAddr1];
   assign rdData2 = (rdAddr2 == '0) ? '0 : regs[rdAddr2];

endmodule

// File: rtl/wb_regfile_writeback.sv
// Write-back stage: selects load data or ALU result, qualifies the write
// enable, commits to the register bank, bypasses the value being written to
// the ID read ports in the same cycle and counts committed writes.
module wb_regfile_writeback
   import mips_pkg::*;
#(
   parameter int DATA_W = mips_pkg::DATA_W,
   parameter int ADDR_W = mips_pkg::ADDR_W,
   parameter bit BYPASS = 1'b1
) (
   input logic                  clk,
   input logic                  rst_n,
   wb_regfile_writeback_if.slave bus
);

   logic [DATA_W-1:0] wbData;
   logic              wbEn;
   logic [DATA_W-1:0] bankRd1;
   logic [DATA_W-1:0] bankRd2;
   logic [DATA_W-1:0] readData1;
   logic [DATA_W-1:0] readData2;
   logic [31:0]       writeCount;

   assign wbData = bus.in_MemToReg ? bus.in_MemDatos_WB : bus.in_ALU_WB;
   assign wbEn   = bus.in_RegWrite && (bus.in_WriteReg != REG_ZERO);

   wb_regfile_writeback_reg_bank #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_regBank (
      .clk     (clk),
      .rst_n   (rst_n),
      .wrEn    (wbEn),
      .wrAddr  (bus.in_WriteReg),
      .wrData  (wbData),
      .rdAddr1 (bus.in_ReadReg1),
      .rdAddr2 (bus.in_ReadReg2),
      .rdData1 (bankRd1),
      .rdData2 (bankRd2)
   );

   // Read-port select: zero during reset or for r0, bypass on a same-cycle write hit.
   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
      readData1 = bankRd1;
      readData2 = bankRd2;
      if (!rst_n || (bus.in_ReadReg1 == REG_ZERO)) begin
         readData1 = '0;
      end else if (BYPASS && wbEn && (bus.in_WriteReg == bus.in_ReadReg1)) begin
         readData1 = wbData;
      end
      if (!rst_n || (bus.in_ReadReg2 == REG_ZERO)) begin
         readData2 = '0;
      end else if (BYPASS && wbEn && (bus.in_WriteReg == bus.in_ReadReg2)) begin
         readData2 = wbData;
      end
   end

   // Committed-write counter, free-running modulo 2**32.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         writeCount <= '0;
      end else if (wbEn) begin
         writeCount <= writeCount + 32'd1;
      end
   end

   assign bus.out_ReadData1  = readData1;
   assign bus.out_ReadData2  = readData2;
   assign bus.out_WB_Data    = wbData;
   assign bus.out_WB_Addr    = bus.in_WriteReg;
   assign bus.out_WB_En      = wbEn;
   assign bus.out_WriteCount = writeCount;

endmodule

// File: tb/tb_wb_regfile_writeback.sv
// Self-checking bench for wb_regfile_writeback: directed vector table,
// randomized traffic against a register-file model, reset and counter-wrap
// sequences.
module tb_wb_regfile_writeback;
   import mips_pkg::*;

   logic clk;
   logic rst_n;

   wb_regfile_writeback_if bus ();

   wb_regfile_writeback dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int passCnt  = 0;
   int checkCnt = 0;

   // Reference model: architectural register contents and committed-write count.
   logic [31:0] model [32];
   logic [31:0] modelCount;

   typedef struct {
      logic        regWrite;
      logic        memToReg;
      logic [4:0]  writeReg;
      logic [31:0] alu;
      logic [31:0] mem;
      logic [4:0]  rd1;
      logic [4:0]  rd2;
      logic [31:0] expRd1;
      logic [31:0] expRd2;
      logic [31:0] expWbData;
      logic        expWbEn;
      logic [31:0] expCount;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCnt++;
      if (act !== exp) begin
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end else begin
         passCnt++;
      end
   endtask

   task automatic drive(input logic rw, input logic m2r, input logic [4:0] wr,
                        input logic [31:0] alu, input logic [31:0] mem,
                        input logic [4:0] r1, input logic [4:0] r2);
      bus.in_RegWrite    = rw;
      bus.in_MemToReg    = m2r;
      bus.in_WriteReg    = wr;
      bus.in_ALU_WB      = alu;
      bus.in_MemDatos_WB = mem;
      bus.in_ReadReg1    = r1;
      bus.in_ReadReg2    = r2;
   endtask

   function automatic logic [31:0] curData();
      return bus.in_MemToReg ? bus.in_MemDatos_WB : bus.in_ALU_WB;
   endfunction

   function automatic logic curEn();
      return bus.in_RegWrite && (bus.in_WriteReg != 5'd0);
   endfunction

   // Value the ID stage must observe: r0 is zero, the in-flight write wins, else the stored value.
   function automatic logic [31:0] expRead(input logic [4:0] a);
      if (!rst_n || a == 5'd0) return 32'd0;
      if (curEn() && a == bus.in_WriteReg) return curData();
      return model[a];
   endfunction

   // Applied at a rising edge: the in-flight write lands in the model.
   task automatic modelCommit();
      if (rst_n && curEn()) begin
         model[bus.in_WriteReg] = curData();
         modelCount = modelCount + 32'd1;
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      modelCount = 32'd0;
   endtask

   initial begin
      drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
      rst_n = 1'b1;
      modelReset();

      // Directed table, applied right after reset release.
      vecs[0] = '{1'b1, 1'b0, REG_T0, 32'hDEAD_BEEF, 32'h1111_1111, REG_T0, REG_ZERO,
                  32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 1'b1, 32'd0};
      vecs[1] = '{1'b0, 1'b0, REG_T2, 32'h5, 32'h0, REG_T0, REG_T0,
                  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h5, 1'b0, 32'd1};
      vecs[2] = '{1'b1, 1'b1, REG_T1, 32'h0, 32'hCAFE_0001, REG_T1, REG_T1,
                  32'hCAFE_0001, 32'hCAFE_0001, 32'hCAFE_0001, 1'b1, 32'd1};
      vecs[3] = '{1'b1, 1'b0, REG_ZERO, 32'hFFFF_FFFF, 32'h0, REG_ZERO, REG_T1,
                  32'h0, 32'hCAFE_0001, 32'hFFFF_FFFF, 1'b0, 32'd2};
      vecs[4] = '{1'b0, 1'b0, REG_T2, 32'h5, 32'h0, REG_T2, REG_ZERO,
                  32'h0, 32'h0, 32'h5, 1'b0, 32'd2};
      vecs[5] = '{1'b0, 1'b0, REG_SP, 32'h0, 32'h0, REG_T1, REG_T0,
                  32'hCAFE_0001, 32'hDEAD_BEEF, 32'h0, 1'b0, 32'd2};

      // Power-on reset: contents and counter clear without a clock edge.
      #2 rst_n = 1'b0;
      #1;
      check("por_count", bus.out_WriteCount, 32'd0);
      bus.in_ReadReg1 = REG_RA;
      bus.in_ReadReg2 = REG_SP;
      #1;
      check("por_rd1", bus.out_ReadData1, 32'd0);
      check("por_rd2", bus.out_ReadData2, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         drive(vecs[i].regWrite, vecs[i].memToReg, vecs[i].writeReg,
               vecs[i].alu, vecs[i].mem, vecs[i].rd1, vecs[i].rd2);
         #1;
         check($sformatf("vec%0d_rd1", i), bus.out_ReadData1, vecs[i].expRd1);
         check($sformatf("vec%0d_rd2", i), bus.out_ReadData2, vecs[i].expRd2);
         check($sformatf("vec%0d_wbdata", i), bus.out_WB_Data, vecs[i].expWbData);
         check($sformatf("vec%0d_wben", i), {31'd0, bus.out_WB_En}, {31'd0, vecs[i].expWbEn});
         check($sformatf("vec%0d_count", i), bus.out_WriteCount, vecs[i].expCount);
         @(posedge clk);
         modelCommit();
         @(negedge clk);
      end

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         logic [4:0] wr;
         logic [4:0] r1;
         logic [4:0] r2;
         wr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
         r1 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
         r2 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
         drive(1'($urandom_range(0, 3) != 0), 1'($urandom), wr, $urandom, $urandom, r1, r2);
         #1;
         check("rnd_rd1", bus.out_ReadData1, expRead(r1));
         check("rnd_rd2", bus.out_ReadData2, expRead(r2));
         check("rnd_wbdata", bus.out_WB_Data, curData());
         check("rnd_wben", {31'd0, bus.out_WB_En}, {31'd0, curEn()});
         check("rnd_wbaddr", {27'd0, bus.out_WB_Addr}, {27'd0, wr});
         check("rnd_count", bus.out_WriteCount, modelCount);
         @(posedge clk);
         modelCommit();
         @(negedge clk);
      end

      // Mid-run reset: r5 written, then reset clears it immediately.
      drive(1'b1, 1'b0, 5'd5, 32'h1234, 32'h0, 5'd5, REG_ZERO);
      @(posedge clk);
      modelCommit();
      @(negedge clk);
      drive(1'b0, 1'b0, 5'd5, 32'h0, 32'h0, 5'd5, 5'd5);
      #1;
      check("pre_rst_r5", bus.out_ReadData1, 32'h1234);
      rst_n = 1'b0;
      modelReset();
      #1;
      check("rst_r5", bus.out_ReadData1, 32'd0);
      check("rst_count", bus.out_WriteCount, 32'd0);
      drive(1'b1, 1'b0, 5'd5, 32'h9999, 32'h0, 5'd5, 5'd5);
      #1;
      check("rst_nobypass", bus.out_ReadData2, 32'd0);
      check("rst_wben", {31'd0, bus.out_WB_En}, 32'd1);
      check("rst_wbdata", bus.out_WB_Data, 32'h9999);
      @(posedge clk);
      #1;
      check("rst_edge_count", bus.out_WriteCount, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 5'd5, 32'h0, 32'h0, 5'd5, REG_ZERO);
      #1;
      check("rst_nocommit_r5", bus.out_ReadData1, 32'd0);
      drive(1'b1, 1'b0, 5'd5, 32'd77, 32'h0, 5'd5, REG_ZERO);
      #1;
      check("rel_bypass_r5", bus.out_ReadData1, 32'd77);
      @(posedge clk);
      modelCommit();
      #1;
      check("rel_count", bus.out_WriteCount, modelCount);
      @(negedge clk);
      drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd5, REG_ZERO);
      #1;
      check("rel_r5", bus.out_ReadData1, 32'd77);

      // Counter wrap: preload all-ones, one commit returns it to zero.
      @(negedge clk);
      drive(1'b1, 1'b0, 5'd3, 32'hAA, 32'h0, REG_ZERO, REG_ZERO);
      force dut.writeCount = 32'hFFFF_FFFF;
      #1;
      release dut.writeCount;
      #1;
      check("wrap_pre", bus.out_WriteCount, 32'hFFFF_FFFF);
      @(posedge clk);
      #1;
      check("wrap_post", bus.out_WriteCount, 32'd0);
      @(negedge clk);
      drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd3, REG_ZERO);
      #1;
      check("wrap_r3", bus.out_ReadData1, 32'hAA);

      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end

endmodule
